mult_div_ctrl: RTL and testbench

- Multi-cycle sequencer for the HI/LO multiply/divide resource used by the EX stage (MULT, MULTU, DIV, DIVU).
- Latches the operands, runs an iterative shift-add multiply or restoring divide, then applies the sign fix-up.
- Presents `done` and the 64-bit {hi, lo} result, which EX consumes as mult_div_done and mult_div_result.
- Holds the result until the pipeline accepts it, and aborts on flush.

---
 rtl/mult_div_ctrl_pkg.sv | 24 ++
 rtl/mult_div_ctrl_if.sv | 24 ++
 rtl/mult_div_ctrl_div_step.sv | 21 ++
 rtl/mult_div_ctrl.sv | 137 +++++++++++++
 tb/tb_mult_div_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mult_div_ctrl_pkg.sv
// mult_div_ctrl_pkg: funct codes, sequencer state encodings and decode helper for the HI/LO unit
package mult_div_ctrl_pkg;

    localparam int MDC_DATA_W = 32;
    localparam int MDC_CNT_W  = 5;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        MDC_IDLE,
        MDC_MUL,
        MDC_DIV,
        MDC_FIX,
        MDC_DONE
    } mdc_state_e;

    function automatic logic is_md_funct(input logic [5:0] f);
        return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// mult_div_ctrl_if: EX-stage handshake with the HI/LO multiply/divide sequencer
interface mult_div_ctrl_if #(parameter int DATA_W = 32);

    logic                start;
    logic [5:0]          funct;
    logic [DATA_W-1:0]   operand_1;
    logic [DATA_W-1:0]   operand_2;
    logic                accept;
    logic                flush;
    logic                busy;
    logic                done;
    logic [2*DATA_W-1:0] result;

    modport master (
        output start, funct, operand_1, operand_2, accept, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct, operand_1, operand_2, accept, flush,
        output busy, done, result
    );

endinterface

// File: rtl/mult_div_ctrl_div_step.sv
// mult_div_ctrl_div_step: one restoring-division iteration, yielding a quotient bit and the next remainder
module mult_div_ctrl_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] dvsr_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_o
);

    logic [DATA_W:0]   part;
    logic [DATA_W-1:0] diff;

    assign part  = {rem_i, bit_i};
    // when the subtraction succeeds the difference is below the divisor, so it fits DATA_W bits
    assign diff  = part[DATA_W-1:0] - dvsr_i;
    assign q_o   = part >= {1'b0, dvsr_i};
    assign rem_o = q_o ? diff : part[DATA_W-1:0];

endmodule

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer for HI/LO; define MULT_FAST_EN for single-cycle multiplies
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int DATA_W = MDC_DATA_W,
    parameter int CNT_W  = MDC_CNT_W
) (
    input logic           clk,
    input logic           rst_n,
    mult_div_ctrl_if.slave md_io
);

    localparam int W2 = 2 * DATA_W;

    mdc_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [W2-1:0]     acc_q;
    logic [W2-1:0]     result_q;
    logic [DATA_W-1:0] opr_q;
    logic              is_div_q;
    logic              neg_lo_q;
    logic              neg_hi_q;
    logic              busy_q;
    logic              done_q;

    logic              is_sgn;
    logic              is_div;
    logic              sgn_1;
    logic              sgn_2;
    logic [DATA_W-1:0] op1_abs;
    logic [DATA_W-1:0] op2_abs;
    logic [DATA_W:0]   sum_d;
    logic [W2-1:0]     mul_d;
    logic [W2-1:0]     div_d;
    logic [DATA_W-1:0] rem_d;
    logic              q_bit;
    logic [DATA_W-1:0] hi_fix;
    logic [DATA_W-1:0] lo_fix;
    logic [W2-1:0]     fix_d;

    assign is_sgn  = md_io.funct inside {FUNCT_MULT, FUNCT_DIV};
    assign is_div  = md_io.funct inside {FUNCT_DIV, FUNCT_DIVU};
    assign sgn_1   = is_sgn & md_io.operand_1[DATA_W-1];
    assign sgn_2   = is_sgn & md_io.operand_2[DATA_W-1];
    assign op1_abs = sgn_1 ? -md_io.operand_1 : md_io.operand_1;
    assign op2_abs = sgn_2 ? -md_io.operand_2 : md_io.operand_2;

    // shift-add: acc = {partial product, remaining multiplier bits}
    assign sum_d = {1'b0, acc_q[W2-1:DATA_W]} + {1'b0, opr_q};
    assign mul_d = acc_q[0] ? {sum_d, acc_q[DATA_W-1:1]} : {1'b0, acc_q[W2-1:1]};

    // restoring divide: acc = {partial remainder, dividend bits shifting into quotient}
    mult_div_ctrl_div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem_i  (acc_q[W2-1:DATA_W]),
        .dvsr_i (opr_q),
        .bit_i  (acc_q[DATA_W-1]),
        .rem_o  (rem_d),
        .q_o    (q_bit)
    );
    assign div_d = {rem_d, acc_q[DATA_W-2:0], q_bit};

    assign hi_fix = neg_hi_q ? -acc_q[W2-1:DATA_W] : acc_q[W2-1:DATA_W];
    assign lo_fix = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign fix_d  = is_div_q ? {hi_fix, lo_fix} : (neg_lo_q ? -acc_q : acc_q);

`ifdef MULT_FAST_EN
    logic [W2-1:0] ext_1;
    logic [W2-1:0] ext_2;
    logic [W2-1:0] prod_d;

    assign ext_1  = {{DATA_W{sgn_1}}, md_io.operand_1};
    assign ext_2  = {{DATA_W{sgn_2}}, md_io.operand_2};
    assign prod_d = ext_1 * ext_2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MDC_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            opr_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (md_io.flush) begin
            state_q <= MDC_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                MDC_IDLE: if (md_io.start && is_md_funct(md_io.funct)) begin
                    cnt_q    <= '0;
                    is_div_q <= is_div;
                    neg_lo_q <= sgn_1 ^ sgn_2;
                    neg_hi_q <= sgn_1;
`ifdef MULT_FAST_EN
                    if (!is_div) begin
                        result_q <= prod_d;
                        state_q  <= MDC_DONE;
                        done_q   <= 1'b1;
                    end else
`endif
                    begin
                        opr_q   <= is_div ? op2_abs : op1_abs;
                        acc_q   <= {{DATA_W{1'b0}}, is_div ? op1_abs : op2_abs};
                        state_q <= is_div ? MDC_DIV : MDC_MUL;
                        busy_q  <= 1'b1;
                    end
                end
                MDC_MUL, MDC_DIV: begin
                    acc_q <= (state_q == MDC_DIV) ? div_d : mul_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) state_q <= MDC_FIX;
                end
                MDC_FIX: begin
                    result_q <= fix_d;
                    state_q  <= MDC_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                MDC_DONE: if (md_io.accept) begin
                    state_q <= MDC_IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= MDC_IDLE;
            endcase
        end
    end

    assign md_io.busy   = busy_q;
    assign md_io.done   = done_q;
    assign md_io.result = result_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: directed scoreboard bench for mult_div_ctrl results, latency, handshake and flush
module tb_mult_div_ctrl;
    import mult_div_ctrl_pkg::*;

`ifdef MULT_FAST_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb[$];
    logic [63:0] last_res = '0;

    mult_div_ctrl_if bus ();

    mult_div_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea = {{32{a[31]}}, a};
        logic [63:0] eb = {{32{b[31]}}, b};
        case (f)
            FUNCT_MULTU: return {32'd0, a} * {32'd0, b};
            FUNCT_MULT:  return ea * eb;
            FUNCT_DIVU:  return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 0) return {a, a[31] ? 32'd1 : 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
        endcase
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        bus.start = 1'b1;
        bus.funct = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
        sb.push_back(exp);
    endtask

    task automatic wait_done(input int lat, input string tag);
        int n = 0;
        bit busy_ok = 1'b1;
        @(posedge clk);
        #1;
        bus.operand_1 = $urandom;
        bus.operand_2 = $urandom;
        do begin
            @(negedge clk);
            n++;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end while (!bus.done && n < 100);
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " busy while running"}, {63'd0, busy_ok}, 64'd1);
        check({tag, " busy at done"}, {63'd0, bus.busy}, 64'd0);
        check({tag, " result"}, bus.result, sb.pop_front());
        last_res = bus.result;
    endtask

    task automatic finish_op(input int hold, input string tag);
        bit stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.done || bus.result !== last_res) stable = 1'b0;
        end
        if (hold > 0) check({tag, " hold stable"}, {63'd0, stable}, 64'd1);
        bus.accept = 1'b1;
        @(negedge clk);
        bus.accept = 1'b0;
        bus.start = 1'b0;
        check({tag, " idle after accept"}, {62'd0, bus.busy, bus.done}, 64'd0);
        check({tag, " result after accept"}, bus.result, last_res);
    endtask

    initial begin
        logic [5:0]  fs[4] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        bit          seen = 1'b0;
        bus.start = 1'b0;
        bus.funct = '0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.accept = 1'b0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("reset result", bus.result, 64'd0);
        rst_n = 1'b1;

        bus.start = 1'b1;
        bus.funct = 6'h20;
        repeat (3) @(negedge clk);
        check("other funct ignored", {62'd0, bus.busy, bus.done}, 64'd0);
        bus.funct = FUNCT_MULTU;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush beats start", {62'd0, bus.busy, bus.done}, 64'd0);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);

        issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        wait_done(MUL_LAT, "multu max");
        finish_op(0, "multu max");
        issue(FUNCT_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
        wait_done(MUL_LAT, "mult -3*5");
        finish_op(5, "mult -3*5");
        issue(FUNCT_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        wait_done(DIV_LAT, "div -7/2");
        finish_op(0, "div -7/2");
        issue(FUNCT_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E);
        wait_done(DIV_LAT, "divu 100/7");
        finish_op(1, "divu 100/7");
        issue(FUNCT_DIVU, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF);
        wait_done(DIV_LAT, "divu by zero");
        finish_op(0, "divu by zero");
        issue(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        wait_done(DIV_LAT, "div min/-1");
        finish_op(0, "div min/-1");
        issue(FUNCT_DIV, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_00000001);
        wait_done(DIV_LAT, "div -5/0");
        finish_op(0, "div -5/0");

        bus.start = 1'b1;
        bus.funct = FUNCT_DIV;
        bus.operand_1 = 32'd1000;
        bus.operand_2 = 32'd3;
        @(posedge clk);
        repeat (10) @(negedge clk);
        check("busy before flush", {63'd0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush to idle", {62'd0, bus.busy, bus.done}, 64'd0);
        check("flush keeps result", bus.result, last_res);
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("no done after flush", {63'd0, seen}, 64'd0);

        issue(FUNCT_MULTU, 32'd3, 32'd4, 64'd12);
        wait_done(MUL_LAT, "multu 3*4");
        finish_op(0, "multu 3*4");
        for (int i = 0; i < 8; i++) begin
            f = fs[i % 4];
            a = $urandom;
            b = (i == 6) ? 32'd0 : 32'($urandom >> (i * 4));
            issue(f, a, b, model(f, a, b));
            wait_done(f inside {FUNCT_MULT, FUNCT_MULTU} ? MUL_LAT : DIV_LAT, "random op");
            finish_op(i % 3, "random op");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
